// File: rtl/any1_fetch_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : any1_fetch_seq_pkg
// Description : Shared constants for the fetch sequencer: line geometry,
//               instruction size, fetch-state codes and aligner-input field
//               widths.
// Revision    : 1.0 - initial release
// ============================================================================
package any1_fetch_seq_pkg;

    // Cache line geometry and fixed instruction slot size
    localparam int LINE_BITS  = 512;
    localparam int LINE_OFS   = 6;
    localparam int INSN_BYTES = 8;

    // Fetch state codes
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    // Field widths of the aligner input bundle {line, ip, stream, pred, err}
    localparam int SIA_LINE_W = LINE_BITS;
    localparam int SIA_PRED_W = 1;
    localparam int SIA_ERR_W  = 1;

endpackage
`default_nettype wire

// File: rtl/any1_fetch_seq_nextip.sv
`default_nettype none
// ============================================================================
// Module      : any1_fetch_nextip
// Description : Combinational next fetch IP (sequential +8 or predicted
//               target) and same-line test against the current IP.
// Revision    : 1.0 - initial release
// ============================================================================
module any1_fetch_nextip
    import any1_fetch_seq_pkg::*;
#(
    parameter int AWID = 32
) (
    input  logic [AWID-1:0] ip_i,
    input  logic            pred_taken_i,
    input  logic [AWID-1:0] pred_ip_i,
    output logic [AWID-1:0] next_ip_o,
    output logic            same_line_o
);

    // Pick the successor IP; low bits are carried through so misalignment is preserved
    always_comb begin
        next_ip_o   = pred_taken_i ? pred_ip_i : (ip_i + AWID'(INSN_BYTES));
        same_line_o = (next_ip_o[AWID-1:LINE_OFS] == ip_i[AWID-1:LINE_OFS]);
    end

endmodule
`default_nettype wire

// File: rtl/any1_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : any1_fetch_seq
// Description : Instruction-fetch sequencer. Holds the fetch IP and one
//               buffered cache line, requests lines with req/ack, presents
//               {line, ip, stream, pred, err} to the aligner with
//               valid/ready, and handles redirects including ones that
//               arrive while a cache request is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module any1_fetch_seq
    import any1_fetch_seq_pkg::*;
#(
    parameter int              AWID  = 32,
    parameter logic [AWID-1:0] RSTIP = AWID'(32'hFFFC0100),
    parameter int              SWID  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  redirect_i,
    input  logic [AWID-1:0]       redirect_ip_i,
    input  logic                  pred_taken_i,
    input  logic [AWID-1:0]       pred_ip_i,
    output logic                  ic_req_o,
    output logic [AWID-1:0]       ic_adr_o,
    input  logic                  ic_ack_i,
    input  logic [LINE_BITS-1:0]  ic_line_i,
    input  logic                  ic_err_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [SIA_LINE_W-1:0] out_line_o,
    output logic [AWID-1:0]       out_ip_o,
    output logic [SWID-1:0]       out_stream_o,
    output logic                  out_pred_o,
    output logic                  out_err_o
);

    logic [2:0]            state_q,  state_d;
    logic [AWID-1:0]       ip_q,     ip_d;
    logic [LINE_BITS-1:0]  line_q,   line_d;
    logic                  lv_q,     lv_d;
    logic                  err_q,    err_d;
    logic [SWID-1:0]       stream_q, stream_d;
    logic                  pred_q,   pred_d;
    logic                  req_q,    req_d;
    logic [AWID-1:0]       adr_q,    adr_d;

    logic [AWID-1:0]       w_next_ip;
    logic                  w_same_line;
    logic                  w_issue;

    function automatic logic [AWID-1:0] line_base(input logic [AWID-1:0] a);
        return {a[AWID-1:LINE_OFS], {LINE_OFS{1'b0}}};
    endfunction

    any1_fetch_nextip #(
        .AWID (AWID)
    ) u_nextip (
        .ip_i         (ip_q),
        .pred_taken_i (pred_taken_i),
        .pred_ip_i    (pred_ip_i),
        .next_ip_o    (w_next_ip),
        .same_line_o  (w_same_line)
    );

    // The line-valid flag is only ever set in RUN, so it doubles as out_valid
    assign w_issue = lv_q & out_ready_i;

    // Next-state logic: redirect overrides everything, otherwise walk the fetch FSM
    always_comb begin
        state_d  = state_q;
        ip_d     = ip_q;
        line_d   = line_q;
        lv_d     = lv_q;
        err_d    = err_q;
        stream_d = stream_q;
        pred_d   = pred_q;
        req_d    = req_q;
        adr_d    = adr_q;

        if (redirect_i) begin
            // An instruction issued in the same cycle still counts as taken downstream
            if (w_issue) begin
                pred_d = pred_taken_i;
            end
            ip_d     = redirect_ip_i;
            stream_d = stream_q + SWID'(1);
            lv_d     = 1'b0;
            err_d    = 1'b0;
            if (req_q && !ic_ack_i) begin
                // Request still in flight: keep req high and throw the answer away
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_REQ;
                req_d   = 1'b1;
                adr_d   = line_base(redirect_ip_i);
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_i) begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        adr_d   = line_base(ip_q);
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (ic_ack_i) begin
                        line_d  = ic_line_i;
                        lv_d    = 1'b1;
                        err_d   = ic_err_i;
                        req_d   = 1'b0;
                        state_d = ST_RUN;
                    end else if (state_q == ST_REQ) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    // Stale line consumed; req stays high for the redirected line
                    if (ic_ack_i) begin
                        state_d = ST_REQ;
                        adr_d   = line_base(ip_q);
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        pred_d = pred_taken_i;
                        if (err_q) begin
                            // Faulting line issues once, then park until redirected
                            lv_d = 1'b0;
                        end else begin
                            ip_d = w_next_ip;
                            if (!w_same_line) begin
                                lv_d = 1'b0;
                                if (en_i) begin
                                    state_d = ST_REQ;
                                    req_d   = 1'b1;
                                    adr_d   = line_base(w_next_ip);
                                end else begin
                                    state_d = ST_IDLE;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            ip_q     <= RSTIP;
            line_q   <= '0;
            lv_q     <= 1'b0;
            err_q    <= 1'b0;
            stream_q <= '0;
            pred_q   <= 1'b0;
            req_q    <= 1'b0;
            adr_q    <= '0;
        end else begin
            state_q  <= state_d;
            ip_q     <= ip_d;
            line_q   <= line_d;
            lv_q     <= lv_d;
            err_q    <= err_d;
            stream_q <= stream_d;
            pred_q   <= pred_d;
            req_q    <= req_d;
            adr_q    <= adr_d;
        end
    end

    assign ic_req_o     = req_q;
    assign ic_adr_o     = adr_q;
    assign out_valid_o  = lv_q;
    assign out_line_o   = line_q;
    assign out_ip_o     = ip_q;
    assign out_stream_o = stream_q;
    assign out_pred_o   = pred_q;
    assign out_err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_any1_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_any1_fetch_seq
// Description : Self-checking bench for any1_fetch_seq: directed walk through
//               the main fetch scenarios followed by randomized traffic
//               against a behavioural model of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_any1_fetch_seq;

    localparam int AWID = 32;
    localparam int SWID = 4;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         en_i;
    logic         redirect_i;
    logic [31:0]  redirect_ip_i;
    logic         pred_taken_i;
    logic [31:0]  pred_ip_i;
    logic         ic_req_o;
    logic [31:0]  ic_adr_o;
    logic         ic_ack_i;
    logic [511:0] ic_line_i;
    logic         ic_err_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [511:0] out_line_o;
    logic [31:0]  out_ip_o;
    logic [3:0]   out_stream_o;
    logic         out_pred_o;
    logic         out_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    any1_fetch_seq #(
        .AWID  (AWID),
        .RSTIP (32'hFFFC0100),
        .SWID  (SWID)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .redirect_i    (redirect_i),
        .redirect_ip_i (redirect_ip_i),
        .pred_taken_i  (pred_taken_i),
        .pred_ip_i     (pred_ip_i),
        .ic_req_o      (ic_req_o),
        .ic_adr_o      (ic_adr_o),
        .ic_ack_i      (ic_ack_i),
        .ic_line_i     (ic_line_i),
        .ic_err_i      (ic_err_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_line_o    (out_line_o),
        .out_ip_o      (out_ip_o),
        .out_stream_o  (out_stream_o),
        .out_pred_o    (out_pred_o),
        .out_err_o     (out_err_o)
    );

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Activities: 0 = parked, 1 = fetching a wanted
    // line, 2 = waiting out an unwanted line, 3 = handing out a line.
    // ------------------------------------------------------------------
    int           m_act;
    logic [31:0]  m_ip;
    logic [3:0]   m_stream;
    logic [511:0] m_line;
    bit           m_valid;
    bit           m_err;
    bit           m_pred;
    bit           m_req;
    logic [31:0]  m_adr;
    bit           m_take;
    logic [31:0]  m_nxt;

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & 32'hFFFF_FFC0;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_act = 0; m_ip = 32'hFFFC0100; m_stream = 4'd0; m_line = '0;
            m_valid = 0; m_err = 0; m_pred = 0; m_req = 0; m_adr = 32'd0;
        end else begin
            m_take = m_valid && out_ready_i;
            if (redirect_i) begin
                if (m_take) m_pred = pred_taken_i;
                m_ip = redirect_ip_i;
                m_stream = m_stream + 4'd1;
                m_valid = 0;
                m_err = 0;
                if (m_req && !ic_ack_i) begin
                    m_act = 2;
                end else begin
                    m_act = 1; m_req = 1; m_adr = line_of(redirect_ip_i);
                end
            end else if (m_act == 0) begin
                if (en_i) begin
                    m_act = 1; m_req = 1; m_adr = line_of(m_ip);
                end
            end else if (m_act == 1) begin
                if (ic_ack_i) begin
                    m_line = ic_line_i; m_valid = 1; m_err = ic_err_i; m_req = 0; m_act = 3;
                end
            end else if (m_act == 2) begin
                if (ic_ack_i) begin
                    m_act = 1; m_adr = line_of(m_ip);
                end
            end else if (m_take) begin
                m_pred = pred_taken_i;
                if (m_err) begin
                    m_valid = 0;
                end else begin
                    m_nxt = pred_taken_i ? pred_ip_i : m_ip + 32'd8;
                    if ((m_nxt >> 6) != (m_ip >> 6)) begin
                        m_valid = 0;
                        if (en_i) begin
                            m_act = 1; m_req = 1; m_adr = line_of(m_nxt);
                        end else begin
                            m_act = 0;
                        end
                    end
                    m_ip = m_nxt;
                end
            end
        end
    end

    bit cmp_en = 0;

    // Compare every output against the model on the falling edge
    always @(negedge clk_i) begin
        if (cmp_en) begin
            check("ic_req",  {511'd0, ic_req_o},     {511'd0, m_req});
            check("ic_adr",  {480'd0, ic_adr_o},     {480'd0, m_adr});
            check("valid",   {511'd0, out_valid_o},  {511'd0, m_valid});
            check("line",    out_line_o,             m_line);
            check("ip",      {480'd0, out_ip_o},     {480'd0, m_ip});
            check("stream",  {508'd0, out_stream_o}, {508'd0, m_stream});
            check("pred",    {511'd0, out_pred_o},   {511'd0, m_pred});
            check("err",     {511'd0, out_err_o},    {511'd0, m_err});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    bit cache_auto = 0;
    int cwait = 0;

    task automatic tick();
        if (cache_auto) begin
            ic_ack_i = 1'b0;
            ic_err_i = 1'b0;
            if (ic_req_o) begin
                if (cwait == 0) begin
                    ic_ack_i  = 1'b1;
                    ic_line_i = {16{ic_adr_o ^ $urandom}};
                    ic_err_i  = ($urandom_range(0, 15) == 0);
                    cwait     = $urandom_range(0, 3);
                end else begin
                    cwait--;
                end
            end
        end
        @(negedge clk_i);
    endtask

    task automatic ack_line(input logic [511:0] l, input bit e);
        ic_ack_i = 1'b1; ic_line_i = l; ic_err_i = e;
        tick();
        ic_ack_i = 1'b0; ic_err_i = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        check(nm, {480'd0, act}, {480'd0, exp});
    endtask

    logic [511:0] line1, line3, line4, stale;

    initial begin
        rst_ni = 1'b0; en_i = 1'b0; redirect_i = 1'b0; redirect_ip_i = 32'd0;
        pred_taken_i = 1'b0; pred_ip_i = 32'd0; ic_ack_i = 1'b0; ic_line_i = '0;
        ic_err_i = 1'b0; out_ready_i = 1'b0;
        line1 = {16{32'h1111_0001}};
        line3 = {16{32'h3333_0003}};
        line4 = {16{32'h4444_0004}};
        stale = {16{32'hDEAD_BEEF}};

        repeat (2) @(negedge clk_i);
        cmp_en = 1;
        lit("rst_ip",    out_ip_o, 32'hFFFC0100);
        lit("rst_req",   {31'd0, ic_req_o}, 32'd0);
        lit("rst_valid", {31'd0, out_valid_o}, 32'd0);

        // First line: sequential issue through the whole line
        rst_ni = 1'b1; en_i = 1'b1; out_ready_i = 1'b1;
        tick();
        lit("first_req", {31'd0, ic_req_o}, 32'd1);
        lit("first_adr", ic_adr_o, 32'hFFFC0100);
        tick();
        ack_line(line1, 1'b0);
        lit("first_valid", {31'd0, out_valid_o}, 32'd1);
        lit("first_ip", out_ip_o, 32'hFFFC0100);
        for (int k = 1; k < 8; k++) begin
            tick();
            lit("seq_ip", out_ip_o, 32'hFFFC0100 + 32'(k) * 32'd8);
        end
        tick();
        lit("next_line_adr", ic_adr_o, 32'hFFFC0140);
        lit("next_line_req", {31'd0, ic_req_o}, 32'd1);

        // Predicted targets: in-line (no request) and out-of-line
        tick();
        ack_line(line1 ^ line3, 1'b0);
        tick();
        lit("pre_pred_ip", out_ip_o, 32'hFFFC0148);
        pred_taken_i = 1'b1; pred_ip_i = 32'hFFFC0168;
        tick();
        lit("pred_in_line_ip", out_ip_o, 32'hFFFC0168);
        lit("pred_in_line_req", {31'd0, ic_req_o}, 32'd0);
        pred_ip_i = 32'h0000_1000;
        tick();
        lit("pred_far_adr", ic_adr_o, 32'h0000_1000);
        lit("pred_far_out", {31'd0, out_pred_o}, 32'd1);
        pred_taken_i = 1'b0;

        // Downstream stall
        tick();
        out_ready_i = 1'b0;
        ack_line(line3, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            lit("stall_ip", out_ip_o, 32'h0000_1000);
            lit("stall_valid", {31'd0, out_valid_o}, 32'd1);
        end

        // Redirect while a request is outstanding, stale ack discarded
        redirect_i = 1'b1; redirect_ip_i = 32'h0000_3000;
        tick();
        redirect_i = 1'b0;
        tick();
        redirect_i = 1'b1; redirect_ip_i = 32'h0000_2008;
        tick();
        redirect_i = 1'b0;
        lit("drain_stream", {28'd0, out_stream_o}, 32'd2);
        ack_line(stale, 1'b0);
        lit("drain_adr", ic_adr_o, 32'h0000_2000);
        check("drain_line_kept", out_line_o, line3);
        tick();
        ack_line(line4, 1'b0);
        lit("redir_ip", out_ip_o, 32'h0000_2008);
        check("redir_line", out_line_o, line4);

        // Fetch error: issues once, parks until redirect
        redirect_i = 1'b1; redirect_ip_i = 32'h0000_4000;
        tick();
        redirect_i = 1'b0;
        tick();
        ack_line(line1, 1'b1);
        lit("err_flag", {31'd0, out_err_o}, 32'd1);
        out_ready_i = 1'b1;
        repeat (3) tick();
        lit("err_ip_held", out_ip_o, 32'h0000_4000);
        lit("err_no_valid", {31'd0, out_valid_o}, 32'd0);
        redirect_i = 1'b1; redirect_ip_i = 32'hFFFF_FFF0;
        tick();
        redirect_i = 1'b0;
        lit("err_cleared", {31'd0, out_err_o}, 32'd0);

        // Address wrap at the top of the space
        tick();
        ack_line(line3, 1'b0);
        tick();
        lit("wrap_pre", out_ip_o, 32'hFFFF_FFF8);
        tick();
        lit("wrap_ip", out_ip_o, 32'h0000_0000);
        lit("wrap_adr", ic_adr_o, 32'h0000_0000);
        lit("wrap_req", {31'd0, ic_req_o}, 32'd1);

        // Asynchronous reset in the middle of a fetch
        tick();
        #2 rst_ni = 1'b0;
        #1;
        lit("arst_ip", out_ip_o, 32'hFFFC0100);
        lit("arst_req", {31'd0, ic_req_o}, 32'd0);
        lit("arst_adr", ic_adr_o, 32'd0);
        lit("arst_stream", {28'd0, out_stream_o}, 32'd0);
        check("arst_line", out_line_o, '0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Randomized traffic against the model
        cache_auto = 1;
        cwait = 0;
        for (int c = 0; c < 4000; c++) begin
            en_i          = ($urandom_range(0, 9) != 0);
            out_ready_i   = ($urandom_range(0, 3) != 0);
            redirect_i    = ($urandom_range(0, 29) == 0);
            redirect_ip_i = $urandom;
            if ($urandom_range(0, 3) != 0) redirect_ip_i[2:0] = 3'd0;
            pred_taken_i  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1)
                pred_ip_i = m_ip + (32'($urandom_range(0, 15)) << 3);
            else
                pred_ip_i = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
